// File: rtl/dec_pkg.sv
// Shared constants, FSM state type and channel search helpers for the decoder scan controller.
// DEC_SCAN_BLANK_EN adds the BLANK state used for break-before-make blanking.
package dec_pkg;

  localparam int SEL_W   = 3;
  localparam int NCH     = 1 << SEL_W;
  localparam int DWELL_W = 8;

`ifdef DEC_SCAN_BLANK_EN
  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    BLANK
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE,
    ACTIVE
  } state_t;
`endif

  // Returns 0 for an empty mask; callers only use these on non-zero masks.
  function automatic logic [SEL_W-1:0] lowestSet(input logic [NCH-1:0] m);
    logic [SEL_W-1:0] r;
    r = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (m[i]) r = SEL_W'(i);
    end
    return r;
  endfunction

  function automatic logic [SEL_W-1:0] highestSet(input logic [NCH-1:0] m);
    logic [SEL_W-1:0] r;
    r = '0;
    for (int i = 0; i < NCH; i++) begin
      if (m[i]) r = SEL_W'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/dec_next_ch.sv
// Circular next-channel search: the first set mask bit above the current select,
// with a flag raised when the search had to wrap past the top channel.
module dec_next_ch
  import dec_pkg::*;
(
  input  logic [NCH-1:0]   i_mask,
  input  logic [SEL_W-1:0] i_curSel,
  output logic [SEL_W-1:0] o_nextSel,
  output logic             o_isLast
);

  logic [SEL_W-1:0] w_idx;
  logic             w_found;

  // Offsets 1..NCH cover every channel once, ending back on the current one.
  always_comb begin
    o_nextSel = i_curSel;
    o_isLast  = 1'b1;
    w_found   = 1'b0;
    w_idx     = '0;
    for (int i = 1; i <= NCH; i++) begin
      w_idx = SEL_W'(int'(i_curSel) + i);
      if (!w_found && i_mask[w_idx]) begin
        w_found   = 1'b1;
        o_nextSel = w_idx;
        o_isLast  = (int'(i_curSel) + i) >= NCH;
      end
    end
  end

endmodule

// File: rtl/dec_scan_ctrl.sv
// Channel scan sequencer driving the select and enable of a 3-to-8 decoder.
// Define DEC_SCAN_BLANK_EN to insert a one-cycle blank (sel_en low) between channels.
module dec_scan_ctrl
  import dec_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic [NCH-1:0]     mask,
  input  logic [DWELL_W-1:0] dwell,
  input  logic               one_shot,
  output logic [SEL_W-1:0]   sel,
  output logic               sel_en,
  output logic               busy,
  output logic               done,
  output logic               wrap
);

  state_t             r_state;
  logic [SEL_W-1:0]   r_sel;
  logic               r_selEn;
  logic               r_busy;
  logic               r_done;
  logic               r_wrap;
  logic [DWELL_W-1:0] r_cnt;
  logic [DWELL_W-1:0] r_dwellLast;
  logic [NCH-1:0]     r_shadowMask;
  logic               r_oneShot;
  logic [SEL_W-1:0]   r_hiSel;

  logic [DWELL_W-1:0] w_dwellLast;
  logic [SEL_W-1:0]   w_startSel;
  logic [SEL_W-1:0]   w_startHi;
  logic [SEL_W-1:0]   w_nextSel;
  logic               w_isLast;

  assign w_dwellLast = (dwell == '0) ? '0 : dwell - 1'b1;
  assign w_startSel  = lowestSet(mask);
  assign w_startHi   = highestSet(mask);

  dec_next_ch u_nextCh (
    .i_mask    (r_shadowMask),
    .i_curSel  (r_sel),
    .o_nextSel (w_nextSel),
    .o_isLast  (w_isLast)
  );

  // done/wrap are registered one edge early so they line up with the final
  // dwell cycle of the top channel rather than trailing it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_sel        <= '0;
      r_selEn      <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_wrap       <= 1'b0;
      r_cnt        <= '0;
      r_dwellLast  <= '0;
      r_shadowMask <= '0;
      r_oneShot    <= 1'b0;
      r_hiSel      <= '0;
    end else begin
      r_done <= 1'b0;
      r_wrap <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start && !stop && (mask != '0)) begin
            r_state      <= ACTIVE;
            r_shadowMask <= mask;
            r_dwellLast  <= w_dwellLast;
            r_oneShot    <= one_shot;
            r_hiSel      <= w_startHi;
            r_sel        <= w_startSel;
            r_cnt        <= w_dwellLast;
            r_selEn      <= 1'b1;
            r_busy       <= 1'b1;
            if ((w_dwellLast == '0) && (w_startSel == w_startHi)) begin
              r_done <= one_shot;
              r_wrap <= !one_shot;
            end
          end
        end
        ACTIVE: begin
          if (stop || ((r_cnt == '0) && w_isLast && r_oneShot)) begin
            r_state <= IDLE;
            r_selEn <= 1'b0;
            r_busy  <= 1'b0;
            r_cnt   <= '0;
          end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
            if ((r_cnt == DWELL_W'(1)) && (r_sel == r_hiSel)) begin
              r_done <= r_oneShot;
              r_wrap <= !r_oneShot;
            end
          end else begin
`ifdef DEC_SCAN_BLANK_EN
            r_state <= BLANK;
            r_sel   <= w_nextSel;
            r_selEn <= 1'b0;
`else
            r_sel <= w_nextSel;
            r_cnt <= r_dwellLast;
            if ((r_dwellLast == '0) && (w_nextSel == r_hiSel)) begin
              r_done <= r_oneShot;
              r_wrap <= !r_oneShot;
            end
`endif
          end
        end
`ifdef DEC_SCAN_BLANK_EN
        BLANK: begin
          if (stop) begin
            r_state <= IDLE;
            r_selEn <= 1'b0;
            r_busy  <= 1'b0;
            r_cnt   <= '0;
          end else begin
            r_state <= ACTIVE;
            r_selEn <= 1'b1;
            r_cnt   <= r_dwellLast;
            if ((r_dwellLast == '0) && (r_sel == r_hiSel)) begin
              r_done <= r_oneShot;
              r_wrap <= !r_oneShot;
            end
          end
        end
`endif
        default: begin
          r_state <= IDLE;
          r_selEn <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign sel    = r_sel;
  assign sel_en = r_selEn;
  assign busy   = r_busy;
  assign done   = r_done;
  assign wrap   = r_wrap;

endmodule

// File: tb/tb_dec_scan_ctrl.sv
// Directed bench for dec_scan_ctrl; expectations follow DEC_SCAN_BLANK_EN when it is defined.
module tb_dec_scan_ctrl;
  import dec_pkg::*;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               start = 1'b0;
  logic               stop = 1'b0;
  logic [NCH-1:0]     mask = '0;
  logic [DWELL_W-1:0] dwell = '0;
  logic               oneShot = 1'b0;
  logic [SEL_W-1:0]   sel;
  logic               selEn;
  logic               busy;
  logic               done;
  logic               wrap;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  dec_scan_ctrl dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .stop     (stop),
    .mask     (mask),
    .dwell    (dwell),
    .one_shot (oneShot),
    .sel      (sel),
    .sel_en   (selEn),
    .busy     (busy),
    .done     (done),
    .wrap     (wrap)
  );

`ifdef DEC_SCAN_BLANK_EN
  localparam int T1_LEN    = 9;
  localparam int ABORT_CYC = 5;
  int t1Sel[9]  = '{0, 0, 2, 2, 2, 5, 5, 5, 5};
  int t1En[9]   = '{1, 1, 0, 1, 1, 0, 1, 1, 0};
  int t1Busy[9] = '{1, 1, 1, 1, 1, 1, 1, 1, 0};
  int t1Done[9] = '{0, 0, 0, 0, 0, 0, 0, 1, 0};
`else
  localparam int T1_LEN    = 7;
  localparam int ABORT_CYC = 4;
  int t1Sel[9]  = '{0, 0, 2, 2, 5, 5, 5, 0, 0};
  int t1En[9]   = '{1, 1, 1, 1, 1, 1, 0, 0, 0};
  int t1Busy[9] = '{1, 1, 1, 1, 1, 1, 0, 0, 0};
  int t1Done[9] = '{0, 0, 0, 0, 0, 1, 0, 0, 0};
`endif

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic iStart, input logic iStop, input logic [NCH-1:0] iMask,
                               input logic [DWELL_W-1:0] iDwell, input logic iOneShot);
    start   = iStart;
    stop    = iStop;
    mask    = iMask;
    dwell   = iDwell;
    oneShot = iOneShot;
  endtask

  task automatic checkOutput(input string tag, input int eSel, input logic eEn, input logic eBusy,
                             input logic eDone, input logic eWrap);
    logic [SEL_W+3:0] obsV;
    logic [SEL_W+3:0] expV;
    obsV = {sel, selEn, busy, done, wrap};
    expV = {SEL_W'(eSel), eEn, eBusy, eDone, eWrap};
    checks++;
    assert (obsV === expV) else begin
      errors++;
      $error("[TB] FAIL %s observed sel/en/busy/done/wrap=%b expected=%b", tag, obsV, expV);
    end
  endtask

  initial begin
    #2;
    checkOutput("reset held", 0, 0, 0, 0, 0);
    stepCycle();
    stepCycle();
    rst_n = 1'b1;
    checkOutput("reset released", 0, 0, 0, 0, 0);

    // One-shot pass over channels 0,2,5; inputs are scrambled mid-scan to prove shadowing.
    $display("[TB] one-shot pass");
    applyStimulus(1, 0, 8'b0010_0101, 8'd2, 1);
    for (int c = 1; c <= T1_LEN; c++) begin
      stepCycle();
      if (c == 1) applyStimulus(0, 0, 8'b0010_0101, 8'd2, 1);
      if (c == 2) applyStimulus(0, 0, 8'hFF, 8'd5, 0);
      checkOutput($sformatf("oneshot c%0d", c), t1Sel[c-1], t1En[c-1][0], t1Busy[c-1][0], t1Done[c-1][0], 1'b0);
    end
    stepCycle();
    checkOutput("oneshot stays idle", 5, 0, 0, 0, 0);

    // Continuous single channel with dwell 0 behaves as dwell 1.
    $display("[TB] continuous single channel");
    applyStimulus(1, 0, 8'h80, 8'd0, 0);
    for (int c = 1; c <= 6; c++) begin
      stepCycle();
      if (c == 1) applyStimulus(0, 0, 8'h80, 8'd0, 0);
      if (c == 3) applyStimulus(1, 0, 8'h01, 8'd4, 1);
      if (c == 4) applyStimulus(0, 0, 8'h01, 8'd4, 1);
`ifdef DEC_SCAN_BLANK_EN
      checkOutput($sformatf("single c%0d", c), 7, logic'(c % 2), 1, 0, logic'(c % 2));
`else
      checkOutput($sformatf("single c%0d", c), 7, 1, 1, 0, 1);
`endif
    end
    applyStimulus(0, 1, 8'h01, 8'd4, 1);
    stepCycle();
    applyStimulus(0, 0, 8'h01, 8'd4, 1);
    checkOutput("single stop", 7, 0, 0, 0, 0);

    // Abort in the second dwell cycle of channel 2, then a start/stop collision.
    $display("[TB] abort and collision");
    applyStimulus(1, 0, 8'b0010_0101, 8'd2, 1);
    for (int c = 1; c <= ABORT_CYC; c++) begin
      stepCycle();
      if (c == 1) applyStimulus(0, 0, 8'b0010_0101, 8'd2, 1);
    end
    checkOutput("abort before stop", 2, 1, 1, 0, 0);
    applyStimulus(0, 1, 8'b0010_0101, 8'd2, 1);
    stepCycle();
    checkOutput("abort idle", 2, 0, 0, 0, 0);
    applyStimulus(1, 1, 8'b0010_0101, 8'd2, 1);
    stepCycle();
    checkOutput("collision idle", 2, 0, 0, 0, 0);
    applyStimulus(0, 0, 8'b0010_0101, 8'd2, 1);
    stepCycle();
    checkOutput("collision settle", 2, 0, 0, 0, 0);

    $display("[TB] zero-mask start");
    applyStimulus(1, 0, 8'h00, 8'd2, 1);
    stepCycle();
    checkOutput("zero mask start", 2, 0, 0, 0, 0);
    applyStimulus(0, 0, 8'h00, 8'd2, 1);
    stepCycle();
    checkOutput("zero mask settle", 2, 0, 0, 0, 0);

`ifdef DEC_SCAN_BLANK_EN
    $display("[TB] stop during blank");
    applyStimulus(1, 0, 8'b0010_0101, 8'd2, 1);
    for (int c = 1; c <= 3; c++) begin
      stepCycle();
      if (c == 1) applyStimulus(0, 0, 8'b0010_0101, 8'd2, 1);
    end
    checkOutput("blank before stop", 2, 0, 1, 0, 0);
    applyStimulus(0, 1, 8'b0010_0101, 8'd2, 1);
    stepCycle();
    applyStimulus(0, 0, 8'b0010_0101, 8'd2, 1);
    checkOutput("blank stop idle", 2, 0, 0, 0, 0);
`endif

    // Asynchronous reset mid-dwell, then a fresh one-shot scan.
    $display("[TB] async reset");
    applyStimulus(1, 0, 8'b0010_0101, 8'd3, 0);
    stepCycle();
    applyStimulus(0, 0, 8'b0010_0101, 8'd3, 0);
    checkOutput("pre-reset c1", 0, 1, 1, 0, 0);
    stepCycle();
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("async reset", 0, 0, 0, 0, 0);
    stepCycle();
    rst_n = 1'b1;
    checkOutput("reset release", 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 8'h02, 8'd2, 1);
    stepCycle();
    applyStimulus(0, 0, 8'h02, 8'd2, 1);
    checkOutput("post-reset c1", 1, 1, 1, 0, 0);
    stepCycle();
    checkOutput("post-reset c2", 1, 1, 1, 1, 0);
    stepCycle();
    checkOutput("post-reset c3", 1, 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
